// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Inputs above 10^DIGITS-1 saturate to all nines and raise o_Overflow.
module bin_to_bcd_converter #(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_Start,
  input  logic [BIN_WIDTH-1:0]  i_Binary,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Overflow,
  output logic [4*DIGITS-1:0]   o_BCD
);

  localparam int unsigned     BCD_W   = 4 * DIGITS;
  localparam int unsigned     CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0]     MAX_VAL = (64'd10 ** DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BIN_WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]           state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]     scratch;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_lat;

  logic [BCD_W-1:0]     adjusted;
  logic [BCD_W-1:0]     next_scratch;
  logic [BIN_WIDTH-1:0] next_bin;
  logic                 in_ovf;
  logic [BIN_WIDTH-1:0] in_sat;

  // Saturating the input keeps every digit within 0..9 at every step.
  always_comb begin
    in_ovf = 64'(i_Binary) > MAX_VAL;
    in_sat = in_ovf ? BIN_WIDTH'(MAX_VAL) : i_Binary;
  end

  always_comb begin
    adjusted = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    next_scratch = {adjusted[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
    next_bin     = {bin_sr[BIN_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_lat    <= 1'b0;
      o_BCD      <= '0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            bin_sr  <= in_sat;
            ovf_lat <= in_ovf;
            scratch <= '0;
            cnt     <= '0;
            o_Busy  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          bin_sr  <= next_bin;
          cnt     <= cnt + 1'b1;
          // The final step's result goes straight to the output register.
          if (cnt == LAST) begin
            o_BCD      <= next_scratch;
            o_Overflow <= ovf_lat;
            o_Done     <= 1'b1;
            o_Busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
